// File: rtl/stopwatch_pkg.sv
// Shared state encoding, time-field limits and width helpers for the stopwatch.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      S_STOP  = 2'b00,
      S_RUN   = 2'b01,
      S_LAP   = 2'b10,
      S_PAUSE = 2'b11
   } state_t;

   localparam int MS_MAX = 999;
   localparam int S_MAX  = 59;

   // Never returns 0 so degenerate parameters still give a legal 1-bit field.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int min_w(input int min_max);
      return clog2_min1(min_max + 1);
   endfunction

   function automatic int idx_w(input int depth);
      return clog2_min1(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_n_sw_btn_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module sw_btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         meta  <= btn;
         sync  <= meta;
         prev  <= sync;
         pulse <= sync & ~prev;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl_n.sv
// Stopwatch controller: button pulses drive a STOP/RUN/LAP/PAUSE FSM over an m:s:ms
// counter with a lap memory; display and lap read port are registered.
module stopwatch_ctrl_n
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_MS = 50000,
   parameter int MIN_MAX      = 99,
   parameter int LAP_DEPTH    = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              sw0,
   input  logic                              sw1,
   input  logic                              sw2,
   output logic [1:0]                        state,
   output logic                              running,
   output logic [min_w(MIN_MAX)-1:0]         disp_m,
   output logic [5:0]                        disp_s,
   output logic [9:0]                        disp_ms,
   output logic [cnt_w(LAP_DEPTH)-1:0]       lap_count,
   output logic                              lap_full,
   input  logic [idx_w(LAP_DEPTH)-1:0]       lap_rd_idx,
   output logic [16+min_w(MIN_MAX)-1:0]      lap_rd_data
);

   localparam int MW = min_w(MIN_MAX);
   localparam int CW = cnt_w(LAP_DEPTH);
   localparam int IW = idx_w(LAP_DEPTH);
   localparam int PW = clog2_min1(TICKS_PER_MS);
   localparam int DW = 16 + MW;

   logic p_start, p_clear, p_lap;

   sw_btn_sync u_sync0 (.clk(clk), .rst(rst), .btn(sw0), .pulse(p_start));
   sw_btn_sync u_sync1 (.clk(clk), .rst(rst), .btn(sw1), .pulse(p_clear));
   sw_btn_sync u_sync2 (.clk(clk), .rst(rst), .btn(sw2), .pulse(p_lap));

   state_t          cur, nxt;
   logic            do_clear, do_lap;
   logic [PW-1:0]   presc;
   logic            ms_tick;
   logic [MW-1:0]   cnt_m;
   logic [5:0]      cnt_s;
   logic [9:0]      cnt_ms;
   logic [DW-1:0]   cur_time;
   logic [DW-1:0]   mem [LAP_DEPTH];

   assign cur_time = {cnt_m, cnt_s, cnt_ms};
   assign ms_tick  = running && (presc == PW'(TICKS_PER_MS - 1));
   assign lap_full = (lap_count == CW'(LAP_DEPTH));
   assign state    = cur;

   // Start outranks clear, which outranks lap; losers in the same cycle are dropped.
   always_comb begin
      nxt      = cur;
      do_clear = 1'b0;
      do_lap   = 1'b0;
      case (cur)
         S_STOP: begin
            if (p_start)      nxt = S_RUN;
            else if (p_clear) do_clear = 1'b1;
         end
         S_RUN: begin
            if (p_start)    nxt = S_PAUSE;
            else if (!p_clear && p_lap) begin
               nxt    = S_LAP;
               do_lap = 1'b1;
            end
         end
         S_LAP: begin
            if (p_start)                nxt = S_PAUSE;
            else if (!p_clear && p_lap) nxt = S_RUN;
         end
         S_PAUSE: begin
            if (p_start) nxt = S_RUN;
            else if (p_clear) begin
               nxt      = S_STOP;
               do_clear = 1'b1;
            end
         end
         default: nxt = S_STOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= S_STOP;
         running <= 1'b0;
      end else begin
         cur     <= nxt;
         running <= (nxt == S_RUN) || (nxt == S_LAP);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || do_clear) begin
         presc  <= '0;
         cnt_m  <= '0;
         cnt_s  <= '0;
         cnt_ms <= '0;
      end else if (running) begin
         presc <= ms_tick ? '0 : presc + 1'b1;
         if (ms_tick) begin
            if (cnt_ms == 10'(MS_MAX)) begin
               cnt_ms <= '0;
               if (cnt_s == 6'(S_MAX)) begin
                  cnt_s <= '0;
                  cnt_m <= (cnt_m == MW'(MIN_MAX)) ? '0 : cnt_m + 1'b1;
               end else begin
                  cnt_s <= cnt_s + 1'b1;
               end
            end else begin
               cnt_ms <= cnt_ms + 1'b1;
            end
         end
      end
   end

   // Entering LAP loads the pre-edge count, which is exactly the captured snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_m  <= '0;
         disp_s  <= '0;
         disp_ms <= '0;
      end else if (!(cur == S_LAP && nxt == S_LAP)) begin
         {disp_m, disp_s, disp_ms} <= cur_time;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || do_clear) begin
         lap_count   <= '0;
         lap_rd_data <= '0;
         for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_lap && !lap_full) begin
            mem[lap_count[IW-1:0]] <= cur_time;
            lap_count              <= lap_count + 1'b1;
         end
         lap_rd_data <= (CW'(lap_rd_idx) < lap_count) ? mem[lap_rd_idx] : '0;
      end
   end

endmodule

// File: doc/stopwatch_ctrl_n.md
Name: stopwatch_ctrl_n

Overview:
Parametrised successor to the stopwatch control FSM. Integrates button synchronisation and edge detection, the ms/s/min time counter, and a LAP_DEPTH-entry lap memory with a registered read port. Sits between the board push-buttons and the 7-segment display driver. Adds a true clear, lap storage and a configurable tick rate.

Parameters:
TICKS_PER_MS, 50000, clk cycles per millisecond; must be >= 1.
MIN_MAX, 99, largest minute value; the minute counter wraps to 0 after it.
LAP_DEPTH, 8, number of lap entries; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sw0  in  1  start/pause button, raw and asynchronous
sw1  in  1  clear button, raw
sw2  in  1  lap button, raw
state  out  2  FSM state: 00 STOP, 01 RUN, 10 LAP, 11 PAUSE
running  out  1  high in RUN or LAP
disp_m  out  $clog2(MIN_MAX+1)  displayed minutes
disp_s  out  6  displayed seconds, 0..59
disp_ms  out  10  displayed milliseconds, 0..999
lap_count  out  $clog2(LAP_DEPTH+1)  number of laps stored
lap_full  out  1  lap_count == LAP_DEPTH
lap_rd_idx  in  $clog2(LAP_DEPTH)  lap read index
lap_rd_data  out  16+$clog2(MIN_MAX+1)  {m, s, ms} of the selected lap

Behaviour:
- Reset (rst high at a clk edge): state=STOP, all counters, prescaler, lap_count, disp_* and lap_rd_data = 0, sync flops = 0.
- Button path (per button):
  - 2-flop synchroniser followed by a registered rising-edge detect.
  - An input first sampled high at edge k produces a one-cycle pulse; the FSM acts on it at edge k+3.
  - A held button yields exactly one pulse. No debounce; debounce is upstream.
- Simultaneous pulses: priority start(sw0) > clear(sw1) > lap(sw2). Lower-priority pulses in the same cycle are dropped.
- Transitions (no pulse = stay):
  - STOP: start -> RUN. Clear -> stay STOP, zero the time and prescaler, lap_count=0.
  - RUN: start -> PAUSE. Lap -> LAP and capture the current time.
  - LAP: start -> PAUSE. Lap -> RUN (display unfreezes).
  - PAUSE: start -> RUN. Clear -> STOP with the same zeroing as clear in STOP.
  - Clear in RUN/LAP is ignored.
- Lap capture:
  - Store {m, s, ms} as of the capturing edge into entry lap_count, then increment lap_count.
  - If lap_full: do not store, lap_count unchanged; the state transition and display freeze still occur.
- Prescaler:
  - Counts 0..TICKS_PER_MS-1 only in RUN/LAP. ms_tick fires when prescaler == TICKS_PER_MS-1.
  - Holds its value in STOP/PAUSE; cleared only by rst or clear.
- Time counter:
  - ms increments on ms_tick.
  - ms 999 -> 0 carries s; s 59 -> 0 carries m; m MIN_MAX -> 0, silent wrap.
  - The full chain of carries resolves in one cycle (e.g. MIN_MAX:59:999 -> 0:0:0).
- Display:
  - disp_* registered. They show the live time in STOP/RUN/PAUSE and the frozen lap snapshot in LAP.
  - Update the cycle after the counter changes.
  - Entering LAP: disp_* show the captured value from the next cycle, even when the lap was not stored.
- Lap read:
  - lap_rd_data is registered with 1-cycle latency.
  - Index >= lap_count returns 0. Entries are cleared by clear, so they read 0 after a clear.
- rst mid-operation overrides every pulse and count in the same edge.

Decomposition:
- Package stopwatch_pkg: state encoding localparams (S_STOP, S_RUN, S_LAP, S_PAUSE), MS_MAX=999, S_MAX=59, and width functions.
- One sub-module, sw_btn_sync: 2-flop sync plus edge pulse, instantiated three times.
- Time counter, lap RAM (flop array) and FSM live in the top module.

Test Plan:
- TICKS_PER_MS=1: reset, pulse sw0, run 61000 cycles -> state=01, disp_m=1, disp_s=1, disp_ms=0 (±3-cycle sync offset, checked exactly against a model).
- RUN, pulse sw2 at time 0:2:500 -> state=10, display frozen at 0:2:500 while the internal count advances; pulse sw2 again -> state=01, display shows live time; lap_rd_idx=0 -> lap_rd_data={0,2,500} one cycle later.
- LAP_DEPTH=2: take 3 laps -> lap_count=2, lap_full=1, third press still enters LAP with a frozen display, entry 1 unchanged.
- Pulse sw0+sw1+sw2 in the same cycle while in PAUSE -> state=RUN, counters not cleared.
- PAUSE, then sw1 -> state=00, disp 0:0:0, lap_count=0, lap_rd_data=0; sw1 while in RUN -> ignored.
- MIN_MAX=1, preload via run to 1:59:999, one more tick -> 0:0:0. Assert rst mid-RUN alongside an sw0 pulse -> state=00, all outputs 0.
